// File: rtl/laser_scan_if.sv
// Point-input stream and result/DONE bundle of the laser-coverage scheduler.
// master drives points; slave is the scheduler.
interface laser_scan_if #(
   parameter int unsigned CW = 6
);
   logic          pt_valid;
   logic [3:0]    X;
   logic [3:0]    Y;
   logic          pt_ready;
   logic          busy;
   logic [3:0]    C_X;
   logic [3:0]    C_Y;
   logic [CW-1:0] HIT_CNT;
   logic          DONE;

   modport master (
      output pt_valid, X, Y,
      input  pt_ready, busy, C_X, C_Y, HIT_CNT, DONE
   );

   modport slave (
      input  pt_valid, X, Y,
      output pt_ready, busy, C_X, C_Y, HIT_CNT, DONE
   );
endinterface

// File: rtl/laser_scan_ctrl.sv
// Best-circle search scheduler: buffers NPTS points, then sweeps all 256 grid centres,
// time-sharing LANES radius-4 comparators over the buffer, and reports the best centre.
module laser_scan_ctrl #(
   parameter int unsigned NPTS  = 40,
   parameter int unsigned LANES = 4,
   parameter int unsigned CW    = 6
) (
   input  logic         CLK,
   input  logic         RST,
   laser_scan_if.slave  bus
);

   localparam int unsigned G  = (NPTS + LANES - 1) / LANES;
   localparam int unsigned GW = (G > 1) ? $clog2(G) : 1;
   localparam int unsigned IW = (NPTS > 1) ? $clog2(NPTS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN, S_DONE} state_e;

   state_e        state_q, state_d;
   logic [3:0]    px_q [NPTS];
   logic [3:0]    py_q [NPTS];
   logic [IW-1:0] ld_q, ld_d;
   logic [3:0]    cx_q, cx_d, cy_q, cy_d;
   logic [GW-1:0] grp_q, grp_d;
   logic [CW-1:0] acc_q, acc_d, best_cnt_q, best_cnt_d;
   logic [3:0]    best_x_q, best_x_d, best_y_q, best_y_d;
   logic [3:0]    res_x_q, res_x_d, res_y_q, res_y_d;
   logic [CW-1:0] res_cnt_q, res_cnt_d;
   logic          pt_ready_q, pt_ready_d, busy_q, busy_d, done_q, done_d;

   logic          wr_en;
   logic [IW-1:0] wr_idx;
   logic          start_scan;
   logic [CW-1:0] partial, total;

   // Squared distance <= 16 on 4-bit coordinates, evaluated without squaring.
   function automatic logic in_circle(input logic [3:0] ax, input logic [3:0] ay,
                                      input logic [3:0] bx, input logic [3:0] by);
      logic [3:0] dx, dy;
      logic [4:0] s;
      dx = (ax >= bx) ? (ax - bx) : (bx - ax);
      dy = (ay >= by) ? (ay - by) : (by - ay);
      s  = 5'(dx) + 5'(dy);
      return (s <= 5'd4) || (dx == 4'd2 && dy == 4'd3) || (dx == 4'd3 && dy == 4'd2);
   endfunction

   // Lane hits for the current group; lanes past the end of the buffer count zero.
   always_comb begin
      partial = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         if ((32'(grp_q) * LANES + l) < NPTS) begin
            partial = partial + CW'(in_circle(cx_q, cy_q,
                                              px_q[IW'(32'(grp_q) * LANES + l)],
                                              py_q[IW'(32'(grp_q) * LANES + l)]));
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      ld_d       = ld_q;
      cx_d       = cx_q;
      cy_d       = cy_q;
      grp_d      = grp_q;
      acc_d      = acc_q;
      best_cnt_d = best_cnt_q;
      best_x_d   = best_x_q;
      best_y_d   = best_y_q;
      res_x_d    = res_x_q;
      res_y_d    = res_y_q;
      res_cnt_d  = res_cnt_q;
      wr_en      = 1'b0;
      wr_idx     = '0;
      start_scan = 1'b0;
      total      = acc_q + partial;

      case (state_q)
         S_IDLE: begin
            if (bus.pt_valid) begin
               wr_en = 1'b1;
               ld_d  = IW'(1);
               if (NPTS == 1) begin
                  start_scan = 1'b1;
               end else begin
                  state_d = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            if (bus.pt_valid) begin
               wr_en  = 1'b1;
               wr_idx = ld_q;
               if (ld_q == IW'(NPTS - 1)) begin
                  start_scan = 1'b1;
               end else begin
                  ld_d = ld_q + IW'(1);
               end
            end
         end
         S_SCAN: begin
            if (grp_q == GW'(G - 1)) begin
               // Strict compare keeps the earliest centre on ties.
               if (total > best_cnt_q) begin
                  best_cnt_d = total;
                  best_x_d   = cx_q;
                  best_y_d   = cy_q;
               end
               acc_d = '0;
               grp_d = '0;
               cx_d  = cx_q + 4'd1;
               if (cx_q == 4'd15) begin
                  cy_d = cy_q + 4'd1;
                  if (cy_q == 4'd15) begin
                     state_d   = S_DONE;
                     res_x_d   = best_x_d;
                     res_y_d   = best_y_d;
                     res_cnt_d = best_cnt_d;
                  end
               end
            end else begin
               acc_d = total;
               grp_d = grp_q + GW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (start_scan) begin
         state_d    = S_SCAN;
         ld_d       = '0;
         cx_d       = '0;
         cy_d       = '0;
         grp_d      = '0;
         acc_d      = '0;
         best_cnt_d = '0;
         best_x_d   = '0;
         best_y_d   = '0;
      end

      pt_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
      busy_d     = (state_d == S_SCAN);
      done_d     = (state_d == S_DONE);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= S_IDLE;
         ld_q       <= '0;
         cx_q       <= '0;
         cy_q       <= '0;
         grp_q      <= '0;
         acc_q      <= '0;
         best_cnt_q <= '0;
         best_x_q   <= '0;
         best_y_q   <= '0;
         res_x_q    <= '0;
         res_y_q    <= '0;
         res_cnt_q  <= '0;
         pt_ready_q <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ld_q       <= ld_d;
         cx_q       <= cx_d;
         cy_q       <= cy_d;
         grp_q      <= grp_d;
         acc_q      <= acc_d;
         best_cnt_q <= best_cnt_d;
         best_x_q   <= best_x_d;
         best_y_q   <= best_y_d;
         res_x_q    <= res_x_d;
         res_y_q    <= res_y_d;
         res_cnt_q  <= res_cnt_d;
         pt_ready_q <= pt_ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Point buffer.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int unsigned i = 0; i < NPTS; i++) begin
            px_q[i] <= '0;
            py_q[i] <= '0;
         end
      end else if (wr_en) begin
         px_q[wr_idx] <= bus.X;
         py_q[wr_idx] <= bus.Y;
      end
   end

   assign bus.pt_ready = pt_ready_q;
   assign bus.busy     = busy_q;
   assign bus.DONE     = done_q;
   assign bus.C_X      = res_x_q;
   assign bus.C_Y      = res_y_q;
   assign bus.HIT_CNT  = res_cnt_q;

endmodule

// File: tb/tb_laser_scan_ctrl.sv
// Bench for laser_scan_ctrl: directed frame table, reset/gap/noise sequences, narrow-lane
// variants, and random frames checked against a brute-force coverage model.
module tb_laser_scan_ctrl;

   localparam int unsigned NPTS = 40;
   localparam int unsigned CW   = 6;

   logic       clk = 1'b0;
   logic       rst, rst_aux, pv, aux_en;
   logic [3:0] xv, yv;

   always #5 clk = ~clk;

   laser_scan_if #(.CW(CW)) bus  ();
   laser_scan_if #(.CW(CW)) bus1 ();
   laser_scan_if #(.CW(CW)) bus3 ();

   assign bus.pt_valid  = pv;
   assign bus.X         = xv;
   assign bus.Y         = yv;
   assign bus1.pt_valid = pv & aux_en;
   assign bus1.X        = xv;
   assign bus1.Y        = yv;
   assign bus3.pt_valid = pv & aux_en;
   assign bus3.X        = xv;
   assign bus3.Y        = yv;

   laser_scan_ctrl #(.NPTS(NPTS), .LANES(4), .CW(CW)) dut  (.CLK(clk), .RST(rst),     .bus(bus));
   laser_scan_ctrl #(.NPTS(NPTS), .LANES(1), .CW(CW)) dut1 (.CLK(clk), .RST(rst_aux), .bus(bus1));
   laser_scan_ctrl #(.NPTS(NPTS), .LANES(3), .CW(CW)) dut3 (.CLK(clk), .RST(rst_aux), .bus(bus3));

   int tests = 0;
   int fails = 0;
   int px [NPTS];
   int py [NPTS];

   typedef struct {
      string name;
      int    na, ax, ay, bx, by;
      bit    gaps, noise;
      int    ex, ey, ec;
   } vec_t;

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic fill(input int na, input int ax, input int ay, input int bx, input int by);
      for (int i = 0; i < NPTS; i++) begin
         px[i] = (i < na) ? ax : bx;
         py[i] = (i < na) ? ay : by;
      end
   endtask

   // Best centre by exhaustive search over the grid using true squared distance.
   function automatic void model(output int bx, output int by, output int bc);
      bx = 0; by = 0; bc = 0;
      for (int cy = 0; cy < 16; cy++) begin
         for (int cx = 0; cx < 16; cx++) begin
            int n = 0;
            for (int i = 0; i < NPTS; i++)
               if ((cx - px[i]) * (cx - px[i]) + (cy - py[i]) * (cy - py[i]) <= 16) n++;
            if (n > bc) begin
               bc = n; bx = cx; by = cy;
            end
         end
      end
   endfunction

   task automatic load_points(input bit gaps);
      int not_ready = 0;
      for (int i = 0; i < NPTS; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
               @(negedge clk);
               pv = 1'b0;
            end
         end
         @(negedge clk);
         if (!bus.pt_ready) not_ready++;
         pv = 1'b1;
         xv = 4'(px[i]);
         yv = 4'(py[i]);
      end
      @(posedge clk);
      #1;
      pv = 1'b0;
      chk("ready_during_load", not_ready, 0);
   endtask

   task automatic run_check(input string nm, input bit noise, input int ex, input int ey, input int ec);
      int cyc = 0, lat = -1, busy_cnt = 0;
      while (lat < 0 && cyc < 2560 + 200) begin
         if (bus.busy) busy_cnt++;
         @(posedge clk);
         cyc++;
         #1;
         if (bus.DONE) lat = cyc;
         pv = noise && (lat < 0) && (cyc % 5 == 0);
         xv = 4'd15;
         yv = 4'd15;
      end
      chk({nm, "_latency"}, lat, 2560);
      chk({nm, "_busy_cycles"}, busy_cnt, 2560);
      chk({nm, "_cx"}, int'(bus.C_X), ex);
      chk({nm, "_cy"}, int'(bus.C_Y), ey);
      chk({nm, "_hit"}, int'(bus.HIT_CNT), ec);
      @(posedge clk);
      #1;
      chk({nm, "_done_pulse"}, int'(bus.DONE), 0);
      chk({nm, "_ready_after"}, int'(bus.pt_ready), 1);
      chk({nm, "_hold_hit"}, int'(bus.HIT_CNT), ec);
   endtask

   vec_t vecs [6];

   initial begin
      int lat1 = -1, lat3 = -1, d1 = 0, d3 = 0;
      int mx, my, mc, ccx, ccy;

      vecs[0] = '{"same55",    40, 5, 5,  5, 5,   1'b0, 1'b0, 5, 1, 40};
      vecs[1] = '{"split30",   30, 0, 0,  15, 15, 1'b0, 1'b0, 0, 0, 30};
      vecs[2] = '{"tie20",     20, 2, 2,  13, 13, 1'b0, 1'b0, 0, 0, 20};
      vecs[3] = '{"gapnoise",  40, 5, 5,  5, 5,   1'b1, 1'b1, 5, 1, 40};
      vecs[4] = '{"corner015", 40, 0, 15, 0, 15,  1'b0, 1'b0, 0, 11, 40};
      vecs[5] = '{"corner150", 40, 15, 0, 15, 0,  1'b0, 1'b0, 11, 0, 40};

      rst = 1'b1; rst_aux = 1'b1; pv = 1'b0; aux_en = 1'b0; xv = '0; yv = '0;
      #23;
      chk("rst_ready", int'(bus.pt_ready), 1);
      chk("rst_busy",  int'(bus.busy), 0);
      chk("rst_done",  int'(bus.DONE), 0);
      chk("rst_cx",    int'(bus.C_X), 0);
      chk("rst_hit",   int'(bus.HIT_CNT), 0);
      @(negedge clk);
      rst = 1'b0; rst_aux = 1'b0;

      // LANES=1 and LANES=3 variants on the same frame.
      fill(40, 5, 5, 5, 5);
      aux_en = 1'b1;
      load_points(1'b0);
      aux_en = 1'b0;
      for (int cyc = 1; cyc <= 10300; cyc++) begin
         @(posedge clk);
         #1;
         if (bus1.DONE) begin d1++; if (lat1 < 0) lat1 = cyc; end
         if (bus3.DONE) begin d3++; if (lat3 < 0) lat3 = cyc; end
      end
      chk("l1_latency", lat1, 10240);
      chk("l3_latency", lat3, 3584);
      chk("l1_pulses", d1, 1);
      chk("l3_pulses", d3, 1);
      chk("l1_cx", int'(bus1.C_X), 5);
      chk("l1_cy", int'(bus1.C_Y), 1);
      chk("l1_hit", int'(bus1.HIT_CNT), 40);
      chk("l3_cx", int'(bus3.C_X), 5);
      chk("l3_cy", int'(bus3.C_Y), 1);
      chk("l3_hit", int'(bus3.HIT_CNT), 40);

      foreach (vecs[k]) begin
         fill(vecs[k].na, vecs[k].ax, vecs[k].ay, vecs[k].bx, vecs[k].by);
         load_points(vecs[k].gaps);
         run_check(vecs[k].name, vecs[k].noise, vecs[k].ex, vecs[k].ey, vecs[k].ec);
      end

      // Reset in mid-scan discards the frame; a fresh frame then completes normally.
      fill(40, 8, 8, 8, 8);
      load_points(1'b0);
      repeat (1000) @(posedge clk);
      #1;
      chk("hold_during_scan_cx", int'(bus.C_X), 11);
      chk("busy_mid_scan", int'(bus.busy), 1);
      rst = 1'b1;
      #2;
      chk("midrst_ready", int'(bus.pt_ready), 1);
      chk("midrst_busy",  int'(bus.busy), 0);
      chk("midrst_cx",    int'(bus.C_X), 0);
      chk("midrst_cy",    int'(bus.C_Y), 0);
      chk("midrst_hit",   int'(bus.HIT_CNT), 0);
      @(negedge clk);
      rst = 1'b0;
      load_points(1'b0);
      run_check("after_rst", 1'b0, 8, 4, 40);

      // Random clustered frames against the model.
      for (int r = 0; r < 3; r++) begin
         ccx = $urandom_range(0, 15);
         ccy = $urandom_range(0, 15);
         for (int i = 0; i < NPTS; i++) begin
            if ($urandom_range(0, 2) != 0) begin
               px[i] = ccx + $urandom_range(0, 6) - 3;
               py[i] = ccy + $urandom_range(0, 6) - 3;
               if (px[i] < 0) px[i] = 0;
               if (px[i] > 15) px[i] = 15;
               if (py[i] < 0) py[i] = 0;
               if (py[i] > 15) py[i] = 15;
            end else begin
               px[i] = $urandom_range(0, 15);
               py[i] = $urandom_range(0, 15);
            end
         end
         model(mx, my, mc);
         load_points(r[0]);
         run_check($sformatf("rand%0d", r), r[0], mx, my, mc);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/laser_scan_ctrl.md
Name: laser_scan_ctrl

Overview:
- Best-circle search scheduler for the laser-coverage datapath.
- Buffers NPTS 4-bit (x,y) points, then sweeps every candidate centre on the 16x16 grid.
- Time-shares LANES in-circle comparator instances (compa) across the point buffer and reports the centre covering the most points.
- Sits between the point-input stream and the result/DONE interface of the top level.

Parameters:
- NPTS, 40, number of points per frame (1..63).
- LANES, 4, comparator instances evaluated per cycle (1..NPTS).
- CW, 6, HIT_CNT width; must satisfy 2^CW > NPTS.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset, asynchronous, active-high.
- pt_valid  input  1  point on X/Y is valid this cycle.
- X  input  4  point x coordinate.
- Y  input  4  point y coordinate.
- pt_ready  output  1  high in IDLE/LOAD; a point is accepted on an edge where pt_valid & pt_ready.
- busy  output  1  high in SCAN.
- C_X  output  4  best centre x, registered.
- C_Y  output  4  best centre y, registered.
- HIT_CNT  output  CW  points covered by best centre, registered.
- DONE  output  1  one-cycle pulse, results valid.

Behaviour:
- Reset (async, RST=1): state=IDLE; pt_ready=1; busy=0; DONE=0; C_X=C_Y=0; HIT_CNT=0; point buffer, load index, centre counters, acc, best_cnt and best centre cleared.
- In-circle predicate per lane: dx=|cx-px|, dy=|cy-py|; hit iff dx^2+dy^2 <= 16, i.e. dx+dy<=4 or (dx,dy) in {(2,3),(3,2)}. No 4-bit overflow in the sum.
- Derived constant: G = ceil(NPTS/LANES) groups per centre. Lanes with index >= NPTS in the last group are masked (count 0).
- IDLE: the first accepted point is written to slot 0; state goes to LOAD (or SCAN if NPTS=1).
- LOAD: accepted points fill slots 1..NPTS-1 in order. pt_valid=0 stalls with no effect. The edge accepting slot NPTS-1 enters SCAN with cx=cy=0, grp=0, acc=0, best_cnt=0, best=(0,0).
- SCAN (pt_ready=0, busy=1): pt_valid ignored.
  - Each cycle, group grp (points grp*LANES .. grp*LANES+LANES-1) is compared against centre (cx,cy).
  - partial = popcount of lane hits.
  - If grp<G-1: acc += partial; grp++.
  - If grp==G-1: total = acc+partial. If total > best_cnt (strictly greater), best_cnt=total and best=(cx,cy). Then acc=0, grp=0, advance centre.
- Scan order: cx inner 0..15, cy outer 0..15. Ties keep the earliest centre in scan order.
- After the last group of centre (15,15), state goes to DONE and C_X/C_Y/HIT_CNT load best/best_cnt on that same edge.
- Latency: last point accepted at edge t0; DONE high in the cycle following edge t0 + 256*G (2560 for defaults).
- DONE state lasts exactly one cycle with DONE=1, then IDLE with pt_ready=1.
- C_X/C_Y/HIT_CNT hold until the next DONE or reset. Loading a new frame does not clear them.
- Reset mid-LOAD or mid-SCAN: immediate return to reset values; the partial frame is discarded.
- All points identical: count NPTS is still correct, since HIT_CNT max equals NPTS < 2^CW.
- A result of 0 is impossible: every point is covered by its own centre, so HIT_CNT >= 1.

Test Plan:
- 40 points all at (5,5), defaults -> DONE after 2560 cycles post-last-point; C=(5,1), HIT_CNT=40 (first centre in scan order within radius 4).
- 30 points at (0,0), 10 at (15,15) -> C=(0,0), HIT_CNT=30.
- Tie-break: 20 at (2,2), 20 at (13,13) -> C=(0,0), HIT_CNT=20; centres near (13,13) also reach 20 but must not replace it.
- Load with pt_valid gaps, plus pt_valid pulses during SCAN carrying (15,15) -> gaps stall only; SCAN-time points ignored; result identical to the gap-free run; busy high for exactly 2560 cycles.
- RST asserted 1000 cycles into SCAN, then a fresh frame of 40 points at (8,8) -> outputs zero during reset; new run gives C=(8,4), HIT_CNT=40, single DONE pulse.
- LANES=1 and LANES=3 (NPTS=40, last group masked), same stimulus as the first scenario -> DONE at 10240 and 3584 cycles respectively; identical C and HIT_CNT.
